dma_device_arbiter: RTL and testbench
=====================================

# dma_device_arbiter

Shares the single DMA controller request port among `N_DEV` DMA-capable peripherals (simple DMA devices and similar). Round-robin arbitration grants one device at a time and forwards its request, address, word count, direction and write data to the controller. Controller ack, end, error and read data are routed back to the granted device only. A per-transfer watchdog aborts a grant when the controller stops acknowledging.

## Interface
- `N_DEV`, 4: number of requesting devices, 2..8.
- `ID_WD`, 2: width of grant index; `N_DEV <= 2**ID_WD` required.
- `TIMEOUT`, 1024: max cycles in BUSY without `dma_ack`; 0 disables watchdog.
- `CNT_WD`, 16: watchdog counter width; `TIMEOUT < 2**CNT_WD` required.

- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `dev_rqst` in N_DEV: per-device DMA request (level).
- `dev_rd_wr` in N_DEV: per-device direction, 1 read / 0 write.
- `dev_start_addr` in 16*N_DEV: packed start addresses, device i at [16i+15:16i].
- `dev_num_words` in 16*N_DEV: packed word counts.
- `dev_wdata` in 16*N_DEV: packed write data.
- `dev_hs_ack` in N_DEV: per-device 2-phase handshake ack.
- `dev_dma_ack` out N_DEV: routed `dma_ack`.
- `dev_end_flag` out N_DEV: routed end flag.
- `dev_error_flag` out N_DEV: routed error / watchdog abort.
- `dev_rdata` out 16: `dma_dev_in` broadcast to all devices.
- `dma_rqst` out 1: request to controller.
- `dma_rd_wr` out 1; `dma_start_address` out 16; `dma_num_words` out 16; `dma_dev_out` out 16; `dma_dev_ack` out 1: granted device's fields.
- `dma_ack`, `dma_end_flag`, `dma_error_flag` in 1 each; `dma_dev_in` in 16: from controller.
- `busy` out 1: state != IDLE.
- `grant_id` out ID_WD: registered grant index.
- `timeout_pulse` out 1: one-cycle pulse on watchdog abort.

## Operation
- States IDLE, BUSY, RELEASE (2-bit state, RELEASE has a 1-bit sub-counter).
- Reset: state IDLE, `grant_id`=0, `last_grant`=N_DEV-1 (device 0 wins first), watchdog=0. All outputs 0 except `dev_rdata`=`dma_dev_in`.
- IDLE: if any `dev_rqst`, pick first requester searching from `last_grant+1` modulo N_DEV. Register `grant_id` and `last_grant`, go BUSY. Nothing requested: stay.
- BUSY: `dma_rqst = dev_rqst[grant_id]`. `dma_rd_wr`, `dma_start_address`, `dma_num_words`, `dma_dev_out`, `dma_dev_ack` are combinational muxes of the granted device's inputs. `dev_dma_ack`/`dev_end_flag`/`dev_error_flag` bit `grant_id` = controller signal; other bits 0.
- In IDLE/RELEASE all `dma_*` outputs are 0 and no ack/end is routed.
- BUSY exit to RELEASE, priority order: `dma_end_flag` or `dma_error_flag` high (both routed if simultaneous); `dev_rqst[grant_id]` low (device abort, no flags generated); watchdog expiry.
- Watchdog: cleared on IDLE->BUSY and on any cycle with `dma_ack`, else +1 in BUSY. Expiry when count == TIMEOUT-1 with no ack/end/error that cycle. End/error on the expiry cycle wins; no timeout is raised.
- RELEASE: exactly 2 cycles with `dma_rqst`=0, so controller and device see a deasserted request. After a watchdog abort, `dev_error_flag[grant_id]` is held 1 for both RELEASE cycles and `timeout_pulse` is 1 on the first. Then go IDLE.
- Round-robin guarantees that a device re-requesting after release loses to any other pending requester.

## Timing
- Request at IDLE edge k -> `grant_id`/`busy` valid, `dma_rqst`=1 from cycle k+1; 1-cycle arbitration latency.
- Ack/end/error/rdata routing is zero-latency combinational in BUSY.
- End at cycle m -> RELEASE at m+1, m+2; IDLE at m+3; next grant earliest m+4 with `dma_rqst` at m+4.
- Timeout with TIMEOUT=T: last ack at cycle a -> RELEASE at a+T (no ack a+1..a+T-1).
- Reset mid-operation: `dma_rqst` and all routed flags drop asynchronously; state IDLE.

## Test plan
- Single device: dev 2 requests read, addr 0x0200, 4 words -> `dma_rqst` 1 cycle later, `dma_start_address`=0x0200, `dma_num_words`=4, acks routed only to bit 2. End -> RELEASE 2 cycles, then IDLE.
- Contention: devs 0,1,3 request continuously after reset -> grant order 0,1,3,0; each grant waits for its end flag; never two `dev_dma_ack` bits high.
- Watchdog: TIMEOUT=8, no `dma_ack` after grant -> RELEASE 8 cycles after grant, `timeout_pulse` 1 cycle, `dev_error_flag[grant]` high 2 cycles.
- Simultaneous: end and watchdog expiry on the same cycle -> `dev_end_flag` routed, no `timeout_pulse`. `dma_end_flag` and `dma_error_flag` together -> both routed.
- Device abort: dev 1 drops `dev_rqst` mid-transfer -> `dma_rqst`=0 that cycle, RELEASE, no flags; next pending device granted.
- Reset asserted in BUSY -> `dma_rqst`=0 immediately; after release, device 0 has priority.

Source files
------------

// File: rtl/dma_device_arbiter.sv
// dma_device_arbiter: round-robin share of one DMA controller port among N_DEV devices.
// Ports:
//   clk, reset                      clock, async active-high reset
//   dev_rqst/dev_rd_wr/dev_hs_ack   per-device request, direction, handshake ack
//   dev_start_addr/num_words/wdata  packed 16-bit per-device fields, device i at [16i+15:16i]
//   dev_dma_ack/end/error_flag      controller status routed to the granted device only
//   dev_rdata                       controller read data broadcast to all devices
//   dma_*                           granted device's fields to the controller / status from it
//   busy, grant_id, timeout_pulse   arbiter status
module dma_device_arbiter #(
    parameter int unsigned N_DEV   = 4,
    parameter int unsigned ID_WD   = 2,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_WD  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DEV-1:0]      dev_rqst,
    input  logic [N_DEV-1:0]      dev_rd_wr,
    input  logic [16*N_DEV-1:0]   dev_start_addr,
    input  logic [16*N_DEV-1:0]   dev_num_words,
    input  logic [16*N_DEV-1:0]   dev_wdata,
    input  logic [N_DEV-1:0]      dev_hs_ack,
    output logic [N_DEV-1:0]      dev_dma_ack,
    output logic [N_DEV-1:0]      dev_end_flag,
    output logic [N_DEV-1:0]      dev_error_flag,
    output logic [15:0]           dev_rdata,
    output logic                  dma_rqst,
    output logic                  dma_rd_wr,
    output logic [15:0]           dma_start_address,
    output logic [15:0]           dma_num_words,
    output logic [15:0]           dma_dev_out,
    output logic                  dma_dev_ack,
    input  logic                  dma_ack,
    input  logic                  dma_end_flag,
    input  logic                  dma_error_flag,
    input  logic [15:0]           dma_dev_in,
    output logic                  busy,
    output logic [ID_WD-1:0]      grant_id,
    output logic                  timeout_pulse
);
    localparam int unsigned DW = 16;
    localparam logic [CNT_WD-1:0] WD_LAST = CNT_WD'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rel_q, rel_d;
    logic [ID_WD-1:0]    grant_q, grant_d;
    logic [ID_WD-1:0]    last_q, last_d;
    logic [CNT_WD-1:0]   wdog_q, wdog_d;
    logic                to_q, to_d;

    logic                sel_rqst, sel_rd_wr, sel_hs;
    logic [DW-1:0]       sel_addr, sel_nw, sel_wdata;
    logic [N_DEV-1:0]    grant_oh;
    logic                arb_hit;
    logic [ID_WD-1:0]    arb_id;
    int                  arb_idx;
    logic                wd_expire;

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);

    // Select the granted device's inputs.
    always_comb begin
        sel_rqst  = 1'b0;
        sel_rd_wr = 1'b0;
        sel_hs    = 1'b0;
        sel_addr  = '0;
        sel_nw    = '0;
        sel_wdata = '0;
        grant_oh  = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (grant_q == ID_WD'(i)) begin
                sel_rqst    = dev_rqst[i];
                sel_rd_wr   = dev_rd_wr[i];
                sel_hs      = dev_hs_ack[i];
                sel_addr    = dev_start_addr[DW*i +: DW];
                sel_nw      = dev_num_words[DW*i +: DW];
                sel_wdata   = dev_wdata[DW*i +: DW];
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Round-robin: first requester after last_grant; scanning from the far end lets the nearest win.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = '0;
        arb_idx = 0;
        for (int k = int'(N_DEV); k >= 1; k--) begin
            arb_idx = int'(last_q) + k;
            if (arb_idx >= int'(N_DEV)) begin
                arb_idx = arb_idx - int'(N_DEV);
            end
            for (int j = 0; j < int'(N_DEV); j++) begin
                if ((j == arb_idx) && dev_rqst[j]) begin
                    arb_hit = 1'b1;
                    arb_id  = ID_WD'(j);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rel_q   <= 1'b0;
            grant_q <= '0;
            last_q  <= ID_WD'(N_DEV - 1);
            wdog_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rel_q   <= rel_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            to_q    <= to_d;
        end
    end

    // Next state and routed outputs.
    always_comb begin
        state_d           = state_q;
        rel_d             = rel_q;
        grant_d           = grant_q;
        last_d            = last_q;
        wdog_d            = wdog_q;
        to_d              = to_q;
        wd_expire         = 1'b0;
        dma_rqst          = 1'b0;
        dma_rd_wr         = 1'b0;
        dma_start_address = '0;
        dma_num_words     = '0;
        dma_dev_out       = '0;
        dma_dev_ack       = 1'b0;
        dev_dma_ack       = '0;
        dev_end_flag      = '0;
        dev_error_flag    = '0;
        timeout_pulse     = 1'b0;
        dev_rdata         = dma_dev_in;

        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    grant_d = arb_id;
                    last_d  = arb_id;
                    wdog_d  = '0;
                    to_d    = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                dma_rqst          = sel_rqst;
                dma_rd_wr         = sel_rd_wr;
                dma_start_address = sel_addr;
                dma_num_words     = sel_nw;
                dma_dev_out       = sel_wdata;
                dma_dev_ack       = sel_hs;
                dev_dma_ack       = dma_ack        ? grant_oh : '0;
                dev_end_flag      = dma_end_flag   ? grant_oh : '0;
                dev_error_flag    = dma_error_flag ? grant_oh : '0;
                // Counter holds cycles since grant or since the last ack cycle.
                wdog_d    = (dma_ack ? '0 : wdog_q) + CNT_WD'(1);
                wd_expire = (TIMEOUT != 0) && !dma_ack && (wdog_q == WD_LAST);
                if (dma_end_flag || dma_error_flag) begin
                    state_d = ST_RELEASE;
                    rel_d   = 1'b0;
                end else if (!sel_rqst) begin
                    state_d = ST_RELEASE;
                    rel_d   = 1'b0;
                end else if (wd_expire) begin
                    state_d = ST_RELEASE;
                    rel_d   = 1'b0;
                    to_d    = 1'b1;
                end
            end
            ST_RELEASE: begin
                // Watchdog abort is reported as an error held through both release cycles.
                if (to_q) begin
                    dev_error_flag = grant_oh;
                    timeout_pulse  = !rel_q;
                end
                rel_d = 1'b1;
                if (rel_q) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_device_arbiter.sv
// tb_dma_device_arbiter: randomized transfers against a transaction-level model;
// the driver queues per-cycle expectations, a negedge monitor pops and compares.
module tb_dma_device_arbiter;
    localparam int N = 4;
    localparam int T = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       dev_rqst, dev_rd_wr, dev_hs_ack;
    logic [16*N-1:0]    dev_start_addr, dev_num_words, dev_wdata;
    logic [N-1:0]       dev_dma_ack, dev_end_flag, dev_error_flag;
    logic [15:0]        dev_rdata;
    logic               dma_rqst, dma_rd_wr, dma_dev_ack;
    logic [15:0]        dma_start_address, dma_num_words, dma_dev_out;
    logic               dma_ack, dma_end_flag, dma_error_flag;
    logic [15:0]        dma_dev_in;
    logic               busy, timeout_pulse;
    logic [1:0]         grant_id;

    dma_device_arbiter #(.N_DEV(N), .ID_WD(2), .TIMEOUT(T), .CNT_WD(16)) dut (
        .clk(clk), .reset(reset),
        .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr),
        .dev_start_addr(dev_start_addr), .dev_num_words(dev_num_words),
        .dev_wdata(dev_wdata), .dev_hs_ack(dev_hs_ack),
        .dev_dma_ack(dev_dma_ack), .dev_end_flag(dev_end_flag),
        .dev_error_flag(dev_error_flag), .dev_rdata(dev_rdata),
        .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
        .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
        .dma_dev_out(dma_dev_out), .dma_dev_ack(dma_dev_ack),
        .dma_ack(dma_ack), .dma_end_flag(dma_end_flag),
        .dma_error_flag(dma_error_flag), .dma_dev_in(dma_dev_in),
        .busy(busy), .grant_id(grant_id), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // phase: 0 idle, 1 transfer, 2 release
    typedef struct {
        int          phase;
        int          gid;
        bit          rq, rw, hs, ack, endf, errf, to, first;
        logic [15:0] addr, nw, wd, rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    bit          pend[N];
    logic [15:0] m_addr[N], m_nw[N], m_wd[N];
    bit          m_rw[N];
    int          last_g;
    int          g_phase = 0, g_gid = 0;
    bit          g_rq = 1'b0, g_to = 1'b0, g_first = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick();
        int d;
        for (int k = 1; k <= N; k++) begin
            d = (last_g + k) % N;
            if (pend[d]) return d;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int d = 0; d < N; d++) if (pend[d]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_req(input int d);
        if (!pend[d]) begin
            pend[d]   = 1'b1;
            m_addr[d] = 16'($urandom);
            m_nw[d]   = 16'($urandom);
            m_wd[d]   = 16'($urandom);
            m_rw[d]   = 1'($urandom);
        end
    endtask

    task automatic set_bus();
        for (int i = 0; i < N; i++) begin
            dev_rqst[i]               = pend[i];
            dev_rd_wr[i]              = m_rw[i];
            dev_start_addr[16*i +: 16] = m_addr[i];
            dev_num_words[16*i +: 16]  = m_nw[i];
            dev_wdata[16*i +: 16]      = m_wd[i];
        end
        dev_hs_ack = N'($urandom);
        dma_dev_in = 16'($urandom);
    endtask

    task automatic noise_ctrl();
        dma_ack        = 1'($urandom);
        dma_end_flag   = 1'($urandom);
        dma_error_flag = 1'($urandom);
    endtask

    // Queue this cycle's expectation, then advance to #1 after the next edge.
    task automatic cycle();
        exp_t r;
        r.phase = g_phase;  r.gid = g_gid;  r.rq = g_rq;
        r.rw    = m_rw[g_gid];  r.addr = m_addr[g_gid];
        r.nw    = m_nw[g_gid];  r.wd = m_wd[g_gid];
        r.hs    = dev_hs_ack[g_gid];
        r.ack   = dma_ack;  r.endf = dma_end_flag;  r.errf = dma_error_flag;
        r.to    = g_to;  r.first = g_first;  r.rdata = dma_dev_in;
        if (mon_en) sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    // kind: 0 end, 1 end+err, 2 err, 3 device abort, 4 watchdog, 5 end on expiry cycle.
    // len: terminating index for kinds 0-3; la: last ack index (-1 none) for kinds 4-5.
    task automatic do_round(input int kind, input int len, input int la, input bit keep);
        int w, x;
        w = rr_pick();
        g_phase = 0; g_to = 1'b0; g_first = 1'b0; g_rq = 1'b0;
        set_bus(); noise_ctrl(); cycle();
        last_g = w;
        x = (kind >= 4) ? ((la < 0) ? T - 1 : la + T - 1) : len;
        for (int j = 0; j <= x; j++) begin
            if (kind == 3 && j == x) pend[w] = 1'b0;
            set_bus();
            g_phase = 1; g_gid = w; g_rq = pend[w];
            if (kind >= 4) dma_ack = (j == la) ? 1'b1 : ((j < la) ? 1'($urandom) : 1'b0);
            else           dma_ack = 1'($urandom);
            dma_end_flag   = (j == x) && (kind == 0 || kind == 1 || kind == 5);
            dma_error_flag = (j == x) && (kind == 1 || kind == 2 || (kind == 5 && 1'($urandom)));
            cycle();
        end
        if (!keep) pend[w] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            set_bus(); noise_ctrl();
            g_phase = 2; g_gid = w; g_to = (kind == 4); g_first = (r == 0);
            cycle();
        end
    endtask

    exp_t         mr;
    logic [N-1:0] moh;

    always @(negedge clk) begin
        if (mon_en && sb.size() > 0) begin
            mr  = sb.pop_front();
            moh = N'(1) << mr.gid;
            chk("busy", 64'(busy), 64'(mr.phase != 0));
            chk("dev_rdata", 64'(dev_rdata), 64'(mr.rdata));
            if (mr.phase == 1) begin
                chk("grant_id", 64'(grant_id), 64'(mr.gid));
                chk("dma_rqst", 64'(dma_rqst), 64'(mr.rq));
                chk("dma_rd_wr", 64'(dma_rd_wr), 64'(mr.rw));
                chk("dma_start_address", 64'(dma_start_address), 64'(mr.addr));
                chk("dma_num_words", 64'(dma_num_words), 64'(mr.nw));
                chk("dma_dev_out", 64'(dma_dev_out), 64'(mr.wd));
                chk("dma_dev_ack", 64'(dma_dev_ack), 64'(mr.hs));
                chk("dev_dma_ack", 64'(dev_dma_ack), 64'(mr.ack ? moh : '0));
                chk("dev_end_flag", 64'(dev_end_flag), 64'(mr.endf ? moh : '0));
                chk("dev_error_flag", 64'(dev_error_flag), 64'(mr.errf ? moh : '0));
                chk("timeout_pulse_busy", 64'(timeout_pulse), 64'(0));
            end else begin
                chk("dma_outputs_quiet", 64'({dma_rqst, dma_rd_wr, dma_dev_ack, dma_start_address,
                                             dma_num_words, dma_dev_out}), 64'(0));
                chk("dev_ack_quiet", 64'(dev_dma_ack), 64'(0));
                chk("dev_end_quiet", 64'(dev_end_flag), 64'(0));
                chk("dev_error_hold", 64'(dev_error_flag),
                    64'((mr.phase == 2 && mr.to) ? moh : '0));
                chk("timeout_pulse", 64'(timeout_pulse),
                    64'(mr.phase == 2 && mr.to && mr.first));
                if (mr.phase == 2) chk("grant_id_release", 64'(grant_id), 64'(mr.gid));
            end
        end
    end

    initial begin
        int w;
        logic [N-1:0] oh;
        reset = 1'b1;
        last_g = N - 1;
        for (int d = 0; d < N; d++) begin
            pend[d] = 1'b0; m_addr[d] = '0; m_nw[d] = '0; m_wd[d] = '0; m_rw[d] = 1'b0;
        end
        dev_rqst = '0; dev_rd_wr = '0; dev_hs_ack = '0;
        dev_start_addr = '0; dev_num_words = '0; dev_wdata = '0;
        dma_ack = 1'b0; dma_end_flag = 1'b0; dma_error_flag = 1'b0; dma_dev_in = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state with every input active.
        dev_rqst = '1; dev_hs_ack = '1;
        dma_ack = 1'b1; dma_end_flag = 1'b1; dma_error_flag = 1'b1; dma_dev_in = 16'hA5C3;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_dma", 64'({dma_rqst, dma_rd_wr, dma_dev_ack, dma_start_address,
                             dma_num_words, dma_dev_out}), 64'(0));
        chk("rst_dev_flags", 64'({dev_dma_ack, dev_end_flag, dev_error_flag, timeout_pulse}), 64'(0));
        chk("rst_rdata", 64'(dev_rdata), 64'(16'hA5C3));
        dev_rqst = '0; dev_hs_ack = '0;
        dma_ack = 1'b0; dma_end_flag = 1'b0; dma_error_flag = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Contention: 0, 1, 3 request continuously.
        add_req(0); add_req(1); add_req(3);
        repeat (4) do_round(0, $urandom_range(0, T - 2), -1, 1'b1);
        for (int d = 0; d < N; d++) pend[d] = 1'b0;

        // Single read from device 2.
        add_req(2);
        m_addr[2] = 16'h0200; m_nw[2] = 16'd4; m_rw[2] = 1'b1;
        do_round(0, 3, -1, 1'b0);
        // Watchdog with no acks, then watchdog after a late ack.
        add_req(1); do_round(4, 0, -1, 1'b0);
        add_req(3); do_round(4, 0, 2, 1'b0);
        // End arriving on the expiry cycle.
        add_req(0); do_round(5, 0, -1, 1'b0);
        // End and error together.
        add_req(2); do_round(1, 2, -1, 1'b0);
        // Device 1 aborts, device 2 follows.
        add_req(1); add_req(2);
        do_round(3, 2, -1, 1'b0);
        do_round(0, 1, -1, 1'b0);

        // Randomized traffic.
        repeat (60) begin
            for (int d = 0; d < N; d++) if (1'($urandom)) add_req(d);
            if (!any_pend()) begin
                repeat ($urandom_range(1, 2)) begin
                    g_phase = 0; set_bus(); noise_ctrl(); cycle();
                end
                add_req(int'($urandom_range(0, N - 1)));
            end
            do_round(int'($urandom_range(0, 5)), int'($urandom_range(0, T - 2)),
                     int'($urandom_range(0, 4)) - 1, 1'($urandom));
        end

        // Reset in the middle of a transfer.
        for (int d = 0; d < N; d++) add_req(d);
        w = rr_pick();
        g_phase = 0; g_to = 1'b0; g_first = 1'b0;
        set_bus(); noise_ctrl(); cycle();
        last_g = w;
        for (int j = 0; j < 2; j++) begin
            set_bus();
            g_phase = 1; g_gid = w; g_rq = 1'b1;
            dma_ack = 1'($urandom); dma_end_flag = 1'b0; dma_error_flag = 1'b0;
            cycle();
        end
        mon_en = 1'b0;
        set_bus();
        dma_ack = 1'b1; dma_end_flag = 1'b0; dma_error_flag = 1'b0;
        oh = N'(1) << w;
        #1;
        chk("pre_reset_ack_routed", 64'(dev_dma_ack), 64'(oh));
        chk("pre_reset_rqst", 64'(dma_rqst), 64'(1));
        reset = 1'b1;
        #1;
        chk("async_reset_rqst", 64'(dma_rqst), 64'(0));
        chk("async_reset_busy", 64'(busy), 64'(0));
        chk("async_reset_flags", 64'({dev_dma_ack, dev_end_flag, dev_error_flag}), 64'(0));
        chk("async_reset_grant", 64'(grant_id), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_g = N - 1;
        mon_en = 1'b1;
        do_round(0, 2, -1, 1'b0);

        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
